sram_ctrl: RTL and testbench

Synchronous initiator for the 8-bit × 256 asynchronous SRAM macro. It accepts single-beat read/write requests on a clocked valid/ready host port and generates the SRAM strobes: `cs` active-high, `rd` active-low read strobe, and `wr` rising-edge write strobe. Every SRAM-side output is driven directly from a register, so the strobes have no glitches. The block sits between the core datapath and the SRAM and owns all strobe sequencing and setup/hold timing.

---
 rtl/sram_ctrl_if.sv | 21 ++
 rtl/sram_ctrl.sv | 116 +++++++++++
 tb/tb_sram_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Host-side request/response port of the SRAM controller.
// The master issues single-beat requests; the slave (controller) answers with a response pulse.
interface sram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Strobe sequencer for an 8x256 asynchronous SRAM: setup, strobe and hold phases timed by a
// down-counter, with every SRAM-facing output taken straight from a flop.
module sram_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_ctrl_if.slave  host,
  output logic [7:0]  sram_addr,
  output logic [7:0]  sram_din,
  input  logic [7:0]  sram_dout,
  output logic        sram_cs,
  output logic        sram_rd,
  output logic        sram_wr
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SetupLd = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PulseLd = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HoldLd  = 4'(HOLD_CYC - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       we_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rdata_q;
  logic [7:0] addr_q;
  logic [7:0] din_q;
  logic       cs_q;
  logic       rd_q;
  logic       wr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      addr_q      <= 8'h00;
      din_q       <= 8'h00;
      cs_q        <= 1'b0;
      rd_q        <= 1'b1;
      wr_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.req_valid) begin
            we_q    <= host.req_we;
            addr_q  <= host.req_addr;
            din_q   <= host.req_wdata;
            cs_q    <= 1'b1;
            ready_q <= 1'b0;
            cnt_q   <= SetupLd;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == 4'd0) begin
            cnt_q   <= PulseLd;
            state_q <= StStrobe;
            if (we_q) begin
              wr_q <= 1'b1;
            end else begin
              rd_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b1;
            rsp_valid_q <= 1'b1;
            cnt_q       <= HoldLd;
            state_q     <= StHold;
            // Data is sampled while rd is still low, before the strobe returns high.
            if (!we_q) begin
              rdata_q <= sram_dout;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          if (cnt_q == 4'd0) begin
            cs_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host.req_ready = ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rdata_q;
  assign sram_addr      = addr_q;
  assign sram_din       = din_q;
  assign sram_cs        = cs_q;
  assign sram_rd        = rd_q;
  assign sram_wr        = wr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default and stretched timing) each on a behavioural SRAM,
// directed vector table, reset-abort sequence and a randomized run against a memory model.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if bus0();
  sram_ctrl_if bus1();

  logic [7:0] addr0, din0, dout0, addr1, din1, dout1;
  logic       cs0, rd0, wr0, cs1, rd1, wr1;

  sram_ctrl dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (bus0),
    .sram_addr (addr0),
    .sram_din  (din0),
    .sram_dout (dout0),
    .sram_cs   (cs0),
    .sram_rd   (rd0),
    .sram_wr   (wr0)
  );

  sram_ctrl #(
    .SETUP_CYC (2),
    .PULSE_CYC (3),
    .HOLD_CYC  (2)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (bus1),
    .sram_addr (addr1),
    .sram_din  (din1),
    .sram_dout (dout1),
    .sram_cs   (cs1),
    .sram_rd   (rd1),
    .sram_wr   (wr1)
  );

  // Behavioural SRAMs
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int wr_rises0 = 0, bad_wr0 = 0, wr_rises1 = 0, bad_wr1 = 0;
  int bad_stab0 = 0, bad_stab1 = 0, rsp_cnt0 = 0, rd_low1 = 0;
  logic       pcs0 = 1'b0, pcs1 = 1'b0;
  logic [7:0] paddr0 = 8'h00, pdin0 = 8'h00, paddr1 = 8'h00, pdin1 = 8'h00;

  assign dout0 = (cs0 && !rd0) ? mem0[addr0] : 8'hzz;
  assign dout1 = (cs1 && !rd1) ? mem1[addr1] : 8'hzz;

  always @(posedge wr0) begin
    if (cs0 && rd0) begin
      mem0[addr0] = din0;
      wr_rises0++;
    end else begin
      bad_wr0++;
    end
  end

  always @(posedge wr1) begin
    if (cs1 && rd1) begin
      mem1[addr1] = din1;
      wr_rises1++;
    end else begin
      bad_wr1++;
    end
  end

  always @(negedge clk) begin
    if (cs0 && pcs0 && (addr0 != paddr0 || din0 != pdin0)) bad_stab0++;
    if (cs1 && pcs1 && (addr1 != paddr1 || din1 != pdin1)) bad_stab1++;
    pcs0 = cs0; paddr0 = addr0; pdin0 = din0;
    pcs1 = cs1; paddr1 = addr1; pdin1 = din1;
    if (bus0.rsp_valid) rsp_cnt0++;
    if (cs1 && !rd1) rd_low1++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic we, input logic [7:0] a,
                         input logic [7:0] d);
    if (sel == 0) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
    end else begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  function automatic logic get_rsp(input int sel);
    return (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction

  function automatic logic [7:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
  endfunction

  // Called at a negedge; returns at the negedge where req_ready is back high.
  // rsp_n / rdy_n count negedges after the acceptance edge (first one is 1); -1 on timeout.
  task automatic do_access(input int sel, input logic we, input logic [7:0] a,
                           input logic [7:0] d, input bit hold, output logic [7:0] rdata,
                           output int rsp_n, output int rdy_n, output int acc_cyc);
    int n;
    rdata = 8'h00; rsp_n = -1; rdy_n = -1; acc_cyc = -1;
    set_req(sel, 1'b1, we, a, d);
    n = 0;
    while (!get_ready(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(sel)) begin
      check("accept_timeout", 32'(get_ready(sel)), 32'd1);
      set_req(sel, 1'b0, we, a, d);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) set_req(sel, 1'b0, we, a, d);
    n = 1;
    while (!get_rsp(sel) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (get_rsp(sel)) begin
      rsp_n = n;
      rdata = get_rdata(sel);
    end
    while (!get_ready(sel) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (get_ready(sel)) rdy_n = n;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus0.req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus0.rsp_valid), 32'd0);
    check({tag, "_cs"}, 32'(cs0), 32'd0);
    check({tag, "_rd"}, 32'(rd0), 32'd1);
    check({tag, "_wr"}, 32'(wr0), 32'd0);
    check({tag, "_addr"}, 32'(addr0), 32'h00);
    check({tag, "_din"}, 32'(din0), 32'h00);
    check({tag, "_rdata"}, 32'(bus0.rsp_rdata), 32'h00);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         hold;
  } vec_t;

  logic [7:0] ref_mem [256];
  logic [7:0] last_rd;

  initial begin
    vec_t       vecs[6];
    logic [7:0] rdata;
    int         rsp_n, rdy_n, acc, prev_acc, w_snap, r_snap, rl_snap;

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    last_rd = 8'h00;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    check("reset_dut1_rd", 32'(rd1), 32'd1);
    check("reset_dut1_ready", 32'(bus1.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write/read-back, then back-to-back with req_valid held and address extremes
    vecs[0] = '{we: 1'b1, addr: 8'h3C, wdata: 8'hA5, exp_rdata: 8'h00, hold: 1'b0};
    vecs[1] = '{we: 1'b0, addr: 8'h3C, wdata: 8'h00, exp_rdata: 8'hA5, hold: 1'b0};
    vecs[2] = '{we: 1'b1, addr: 8'hFF, wdata: 8'h11, exp_rdata: 8'hA5, hold: 1'b1};
    vecs[3] = '{we: 1'b1, addr: 8'h00, wdata: 8'h22, exp_rdata: 8'hA5, hold: 1'b1};
    vecs[4] = '{we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h11, hold: 1'b1};
    vecs[5] = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h22, hold: 1'b0};
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      w_snap = wr_rises0;
      do_access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                rdata, rsp_n, rdy_n, acc);
      check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_rsp_lat", i), 32'(rsp_n), 32'd4);
      check($sformatf("vec%0d_ready_lat", i), 32'(rdy_n), 32'd5);
      check($sformatf("vec%0d_wr_rises", i), 32'(wr_rises0 - w_snap), vecs[i].we ? 32'd1 : 32'd0);
      if (i >= 3) check($sformatf("vec%0d_acc_gap", i), 32'(acc - prev_acc), 32'd5);
      prev_acc = acc;
      if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
      else last_rd = vecs[i].exp_rdata;
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Reset in the SETUP cycle of a write: no wr edge, no response, memory intact
    w_snap = wr_rises0;
    r_snap = rsp_cnt0;
    set_req(0, 1'b1, 1'b1, 8'h3C, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_setup", 32'(cs0), 32'd1);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check_reset_vals("abort");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_wr", 32'(wr_rises0 - w_snap), 32'd0);
    check("abort_no_rsp", 32'(rsp_cnt0 - r_snap), 32'd0);
    last_rd = 8'h00;
    do_access(0, 1'b0, 8'h3C, 8'h00, 1'b0, rdata, rsp_n, rdy_n, acc);
    check("abort_readback", 32'(rdata), 32'(ref_mem[8'h3C]));
    check("abort_readback_const", 32'(rdata), 32'hA5);
    last_rd = rdata;

    // Stretched timing instance: setup 2, pulse 3, hold 2
    do_access(1, 1'b1, 8'h80, 8'h7E, 1'b0, rdata, rsp_n, rdy_n, acc);
    check("p_wr_rsp_lat", 32'(rsp_n), 32'd6);
    check("p_wr_rise", 32'(wr_rises1), 32'd1);
    repeat (2) @(negedge clk);
    rl_snap = rd_low1;
    do_access(1, 1'b0, 8'h80, 8'h00, 1'b0, rdata, rsp_n, rdy_n, acc);
    check("p_rd_rdata", 32'(rdata), 32'h7E);
    check("p_rd_rsp_lat", 32'(rsp_n), 32'd6);
    check("p_rd_ready_lat", 32'(rdy_n), 32'd8);
    @(negedge clk);
    check("p_rd_low_cycles", 32'(rd_low1 - rl_snap), 32'd3);

    // Randomized accesses against the memory model
    for (int i = 0; i < 40; i++) begin
      logic       we;
      logic [7:0] a, d, exp;
      bit         hold;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      else a = 8'($urandom);
      d = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      if (we) begin
        ref_mem[a] = d;
        exp = last_rd;
      end else begin
        exp = ref_mem[a];
        last_rd = exp;
      end
      do_access(0, we, a, d, hold, rdata, rsp_n, rdy_n, acc);
      check($sformatf("rnd%0d_rdata", i), 32'(rdata), 32'(exp));
      check($sformatf("rnd%0d_rsp_lat", i), 32'(rsp_n), 32'd4);
      check($sformatf("rnd%0d_ready_lat", i), 32'(rdy_n), 32'd5);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    check("wr_edge_legal0", 32'(bad_wr0), 32'd0);
    check("wr_edge_legal1", 32'(bad_wr1), 32'd0);
    check("addr_stable0", 32'(bad_stab0), 32'd0);
    check("addr_stable1", 32'(bad_stab1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
